// File: rtl/simd_alu_arbiter.sv
// simd_alu_arbiter: round-robin sharing of one SIMD ALU between two requesters
// Optional feature: define SIMD_ARB_LOCK_EN to add req0_lock/req1_lock (exclusive ownership).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   reqN_valid/ready                  request handshake for requester N (N=0,1)
//   reqN_a, reqN_b, reqN_opcode       operands and opcode from requester N
//   alu_a, alu_b, alu_opcode          registered operands/opcode to the ALU
//   alu_out, alu_overflow/underflow   ALU result and flags, ALU_LAT cycles after issue
//   rspN_valid/data/overflow/underflow  one-cycle result pulse back to requester N
module simd_alu_arbiter #(
    parameter int DATA_W    = 256,
    parameter int OPC_W     = 4,
    parameter int ALU_LAT   = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OPC_W-1:0]  req0_opcode,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OPC_W-1:0]  req1_opcode,
`ifdef SIMD_ARB_LOCK_EN
    input  logic              req0_lock,
    input  logic              req1_lock,
`endif
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_overflow,
    input  logic              alu_underflow,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_overflow,
    output logic              rsp0_underflow,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_overflow,
    output logic              rsp1_underflow
);
    logic [3:0]       r_outst0, r_outst1;
    logic             r_last;
    logic [ALU_LAT:0] r_tag_v, r_tag_id;
    logic             w_blk0, w_blk1, w_elig0, w_elig1, w_gnt0, w_gnt1;
    logic             w_hs0, w_hs1, w_hs, w_out_v, w_out_id;

`ifdef SIMD_ARB_LOCK_EN
    logic r_lock_v, r_lock_id;
    assign w_blk0 = r_lock_v && r_lock_id;
    assign w_blk1 = r_lock_v && !r_lock_id;
    // Owner dropping valid releases the lock; arbitration stays gated this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_v  <= 1'b0;
            r_lock_id <= 1'b0;
        end else if (r_lock_v && !(r_lock_id ? req1_valid : req0_valid)) begin
            r_lock_v <= 1'b0;
        end else if (w_hs) begin
            r_lock_v  <= w_hs1 ? req1_lock : req0_lock;
            r_lock_id <= w_hs1;
        end
    end
`else
    assign w_blk0 = 1'b0;
    assign w_blk1 = 1'b0;
`endif

    assign w_elig0  = req0_valid && !w_blk0 && (r_outst0 < 4'(MAX_OUTST));
    assign w_elig1  = req1_valid && !w_blk1 && (r_outst1 < 4'(MAX_OUTST));
    // r_last holds the last granted id; reset to 1 so req0 wins the first tie.
    assign w_gnt0   = w_elig0 && (!w_elig1 || r_last);
    assign w_gnt1   = w_elig1 && (!w_elig0 || !r_last);
    assign req0_ready = w_gnt0 && !rst;
    assign req1_ready = w_gnt1 && !rst;
    assign w_hs0    = req0_valid && req0_ready;
    assign w_hs1    = req1_valid && req1_ready;
    assign w_hs     = w_hs0 || w_hs1;
    // Stage ALU_LAT lines up with the cycle alu_out is valid for that issue.
    assign w_out_v  = r_tag_v[ALU_LAT];
    assign w_out_id = r_tag_id[ALU_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_outst0   <= '0;
            r_outst1   <= '0;
            r_tag_v    <= '0;
            r_tag_id   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else begin
            r_outst0 <= r_outst0 + 4'(w_hs0) - 4'(rsp0_valid);
            r_outst1 <= r_outst1 + 4'(w_hs1) - 4'(rsp1_valid);
            r_tag_v  <= {r_tag_v[ALU_LAT-1:0], w_hs};
            r_tag_id <= {r_tag_id[ALU_LAT-1:0], w_hs1};
            if (w_hs) begin
                r_last     <= w_hs1;
                alu_a      <= w_hs1 ? req1_a : req0_a;
                alu_b      <= w_hs1 ? req1_b : req0_b;
                alu_opcode <= w_hs1 ? req1_opcode : req0_opcode;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid     <= 1'b0;
            rsp0_data      <= '0;
            rsp0_overflow  <= 1'b0;
            rsp0_underflow <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp1_data      <= '0;
            rsp1_overflow  <= 1'b0;
            rsp1_underflow <= 1'b0;
        end else begin
            rsp0_valid <= w_out_v && !w_out_id;
            rsp1_valid <= w_out_v && w_out_id;
            if (w_out_v && !w_out_id) begin
                rsp0_data      <= alu_out;
                rsp0_overflow  <= alu_overflow;
                rsp0_underflow <= alu_underflow;
            end
            if (w_out_v && w_out_id) begin
                rsp1_data      <= alu_out;
                rsp1_overflow  <= alu_overflow;
                rsp1_underflow <= alu_underflow;
            end
        end
    end
endmodule

// File: doc/simd_alu_arbiter.md
# simd_alu_arbiter

Round-robin arbiter and sequencer that shares one 256-bit SIMD ALU datapath between two requesters. It accepts operand/opcode transactions over valid/ready handshakes and issues at most one operation per cycle to the ALU. It tracks each in-flight operation through the fixed ALU pipeline latency with a tag shift register, and routes results and overflow/underflow flags back to the originating requester. It sits between the request clients and the ALU top level.

## Interface
- DATA_W, 256, operand/result width
- OPC_W, 4, opcode width (matches ALU opcode encoding)
- ALU_LAT, 2, cycles from ALU inputs driven to alu_out valid; legal range 1..8
- MAX_OUTST, 4, max in-flight operations per requester; legal range 1..15

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- reqN_valid  in  1  (N=0,1) requester N presents an operation
- reqN_ready  out  1  arbiter accepts requester N this cycle
- reqN_a, reqN_b  in  DATA_W  operands
- reqN_opcode  in  OPC_W  ALU opcode, passed through unmodified
- alu_a, alu_b  out  DATA_W  registered operands to ALU
- alu_opcode  out  OPC_W  registered opcode to ALU
- alu_out  in  DATA_W  ALU result
- alu_overflow, alu_underflow  in  1  ALU flags
- rspN_valid  out  1  one-cycle pulse: result for requester N; no backpressure
- rspN_data  out  DATA_W  result
- rspN_overflow, rspN_underflow  out  1  flags belonging to rspN_data

## Operation
- Eligible N = reqN_valid && outst_N < MAX_OUTST.
- Grant (combinational): one eligible requester only. If both are eligible, the one other than the last granted wins. After reset, the priority pointer favours req0.
- reqN_ready = grant N; handshake = reqN_valid && reqN_ready. Pointer updates only on a handshake.
- On handshake: alu_a/alu_b/alu_opcode load the requester's fields; issue tag {valid=1, id=N} enters a tag pipeline of depth ALU_LAT+1.
- No handshake: alu_* hold their previous value; a tag with valid=0 enters the pipeline.
- Tag pipeline output valid: latch alu_out/flags into rsp_id's data/flag registers and pulse rsp_id_valid for one cycle. The non-addressed rsp data holds.
- Per-requester outstanding counter (4 bits): +1 on handshake, −1 on rspN_valid. Both in the same cycle leave it unchanged. Never exceeds MAX_OUTST, never underflows.
- Responses return strictly in issue order; back-to-back issue gives one response per cycle.

## Timing
- Handshake in cycle T → alu_* driven in T+1 → alu_out sampled in T+1+ALU_LAT → rspN_valid high in T+2+ALU_LAT (4 cycles at default).
- Throughput: 1 op/cycle aggregate; alternates 0,1,0,1 when both are continuously eligible.
- Reset (any cycle, including mid-flight): all outputs 0, pointer→req0, counters 0, tag pipeline cleared. In-flight operations are dropped with no response. reqN_ready is 0 during the rst cycle.
- Boundary: outst_N == MAX_OUTST makes N ineligible; the other requester may take every slot. N is eligible again in the cycle after its rspN_valid.

## Configuration
- SIMD_ARB_LOCK_EN defined: adds inputs reqN_lock (1 bit).
  - A handshake with reqN_lock=1 makes N the lock owner. Only the owner can be granted until it completes a handshake with lock=0, or deasserts reqN_valid (lock released that cycle, normal arbitration resumes the next cycle).
  - An owner stalled at MAX_OUTST keeps the lock; the other requester is not granted.
  - Lock state clears on rst.
- Not defined: no reqN_lock ports; pure round-robin as above.

## Test plan
- Single op: req0 valid with ADD8, a=b=0x01 per byte, ALU model returns a+b → req0_ready in T; rsp0_valid exactly at T+4 with data 0x02 per byte; rsp1_valid never asserts.
- Contention: both valid for 8 cycles → grants alternate 0,1,0,1…; 4 responses each, in issue order, each 4 cycles after its handshake.
- Credit limit (MAX_OUTST=4): req0 always valid, req1 idle, ALU_LAT raised to 6 → exactly 4 handshakes, then req0_ready=0 until the cycle after the first rsp0_valid.
- Flags: ALU model asserts overflow on op to req1 only → rsp1_overflow=1 with that response only; rsp0 flags 0.
- Reset mid-flight: 3 ops issued, rst at T+2 → no rspN_valid afterwards; counters 0; next request is granted to req0 when both are valid.
- Lock (SIMD_ARB_LOCK_EN): req1 handshakes with lock=1 for 3 ops, then lock=0 while req0 is valid throughout → req0 granted only after req1's lock=0 handshake.
